// File: rtl/mem_responder.sv
// Byte-wide memory responder: single-port RAM plus an I/O window feeding a TX byte FIFO.
// Optional drop counter enabled by defining MEM_RESP_DROP_CNT_EN.
module mem_responder #(
   parameter int ADDR_WIDTH  = 17,
   parameter int FIFO_AW     = 4,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
`ifdef MEM_RESP_DROP_CNT_EN
   ,
   output logic [15:0] drop_cnt
`endif
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0] MARGIN_C = (FIFO_AW + 1)'(FULL_MARGIN);

   logic [7:0]            ram_r [0:(2 ** ADDR_WIDTH) - 1];
   logic [7:0]            fifo_r [0:DEPTH - 1];
   logic [FIFO_AW:0]      wr_ptr_r;
   logic [FIFO_AW:0]      rd_ptr_r;
   logic [7:0]            mem_din_r;
   logic                  io_full_r;

   logic [ADDR_WIDTH-1:0] ram_addr_s;
   logic                  io_sel_s;
   logic [FIFO_AW:0]      count_s;
   logic [FIFO_AW:0]      next_count_s;
   logic                  full_s;
   logic                  push_req_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  drop_s;
   logic                  unused_s;

   assign unused_s   = ^mem_a[31:18];
   assign ram_addr_s = mem_a[ADDR_WIDTH-1:0];
   assign io_sel_s   = (mem_a[17:16] == 2'b11);
   assign count_s    = wr_ptr_r - rd_ptr_r;
   assign full_s     = (count_s == DEPTH_C);
   assign pop_s      = tx_valid && tx_ready;
   assign push_req_s = rdy_in && mem_wr && io_sel_s;

   // Push/drop decision: a full FIFO still accepts the byte when the head leaves this cycle
   always_comb begin
      push_s       = 1'b0;
      drop_s       = 1'b0;
      next_count_s = count_s;
      if (push_req_s) begin
         if (!full_s || pop_s) begin
            push_s = 1'b1;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
      end
      next_count_s = count_s + (FIFO_AW + 1)'(push_s) - (FIFO_AW + 1)'(pop_s);
   end

   // RAM write port; contents are never reset
   always_ff @(posedge clk_in) begin
      if (rdy_in && mem_wr && !io_sel_s) begin
         ram_r[ram_addr_s] <= mem_dout;
      end
   end

   // FIFO storage write
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         fifo_r[wr_ptr_r[FIFO_AW-1:0]] <= mem_dout;
      end
   end

   // Read data register; holds across writes and while the bus is stalled
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_din_r <= 8'h00;
      end else if (rdy_in && !mem_wr) begin
         mem_din_r <= io_sel_s ? 8'h00 : ram_r[ram_addr_s];
      end
   end

   // FIFO pointers and registered near-full flag
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         io_full_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + (FIFO_AW + 1)'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (FIFO_AW + 1)'(1);
         end
         io_full_r <= ((DEPTH_C - next_count_s) <= MARGIN_C);
      end
   end

`ifdef MEM_RESP_DROP_CNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating count of I/O writes lost to a full FIFO
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         drop_cnt_r <= 16'h0000;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
   end

   assign drop_cnt = drop_cnt_r;
`else
   logic unused_drop_s;
   assign unused_drop_s = drop_s;
`endif

   assign mem_din        = mem_din_r;
   assign io_buffer_full = io_full_r;
   assign tx_valid       = (count_s != (FIFO_AW + 1)'(0));
   assign tx_data        = tx_valid ? fifo_r[rd_ptr_r[FIFO_AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (drop counter checked when MEM_RESP_DROP_CNT_EN is defined).
module tb_mem_responder;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
`ifdef MEM_RESP_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   mem_responder dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .rdy_in(rdy_in),
      .mem_a(mem_a),
      .mem_wr(mem_wr),
      .mem_dout(mem_dout),
      .mem_din(mem_din),
      .io_buffer_full(io_buffer_full),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready)
`ifdef MEM_RESP_DROP_CNT_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
      mem_wr   = wr;
      mem_a    = a;
      mem_dout = d;
   endtask

   initial begin
      rst_n_in = 1'b1;
      rdy_in   = 1'b1;
      tx_ready = 1'b0;
      bus(1'b0, 32'h0, 8'h00);
      #1 rst_n_in = 1'b0;
      #1;
      check("rst_mem_din", {8'h00, mem_din}, 16'h0000);
      check("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
      check("rst_io_full", {15'h0, io_buffer_full}, 16'h0000);
      tick();
      tick();
      rst_n_in = 1'b1;

      // write then read-back next cycle
      bus(1'b1, 32'h10, 8'hA5);
      tick();
      check("wr_holds_din", {8'h00, mem_din}, 16'h0000);
      bus(1'b0, 32'h10, 8'h00);
      tick();
      check("raw_a5", {8'h00, mem_din}, 16'h00A5);

      // preload and stream reads with one stall cycle
      bus(1'b1, 32'h100, 8'h11); tick();
      bus(1'b1, 32'h101, 8'h22); tick();
      bus(1'b1, 32'h102, 8'h33); tick();
      bus(1'b1, 32'h103, 8'h44); tick();
      bus(1'b0, 32'h100, 8'h00); tick();
      check("stream_0", {8'h00, mem_din}, 16'h0011);
      bus(1'b0, 32'h101, 8'h00); tick();
      check("stream_1", {8'h00, mem_din}, 16'h0022);
      rdy_in = 1'b0;
      bus(1'b0, 32'h102, 8'h00); tick();
      check("stall_hold", {8'h00, mem_din}, 16'h0022);
      rdy_in = 1'b1;
      tick();
      check("stream_2", {8'h00, mem_din}, 16'h0033);
      bus(1'b0, 32'h103, 8'h00); tick();
      check("stream_3", {8'h00, mem_din}, 16'h0044);

      // I/O read returns zero
      bus(1'b0, 32'h3ABCD, 8'h00); tick();
      check("io_read_zero", {8'h00, mem_din}, 16'h0000);

      // stalled write must not reach RAM
      rdy_in = 1'b0;
      bus(1'b1, 32'h10, 8'hFF); tick();
      rdy_in = 1'b1;
      bus(1'b0, 32'h10, 8'h00); tick();
      check("stall_no_write", {8'h00, mem_din}, 16'h00A5);
      check("fifo_empty", {15'h0, tx_valid}, 16'h0000);

      // fill FIFO: near-full after the 14th push
      for (int i = 0; i < 14; i++) begin
         bus(1'b1, 32'h30000, 8'h10 + 8'(i));
         tick();
         if (i == 12) check("not_full_13", {15'h0, io_buffer_full}, 16'h0000);
      end
      check("full_after_14", {15'h0, io_buffer_full}, 16'h0001);
      check("head_first", {7'h0, tx_valid, tx_data}, 16'h0110);
      bus(1'b1, 32'h30000, 8'h1E); tick();
      bus(1'b1, 32'h30000, 8'h1F); tick();
      bus(1'b1, 32'h30000, 8'hEE); tick();
`ifdef MEM_RESP_DROP_CNT_EN
      check("drop_cnt_1", drop_cnt, 16'h0001);
`endif
      // full FIFO with simultaneous pop and push
      tx_ready = 1'b1;
      bus(1'b1, 32'h30000, 8'h20); tick();
      check("pushpop_head", {7'h0, tx_valid, tx_data}, 16'h0111);
      check("pushpop_full", {15'h0, io_buffer_full}, 16'h0001);
`ifdef MEM_RESP_DROP_CNT_EN
      check("drop_cnt_still_1", drop_cnt, 16'h0001);
`endif
      bus(1'b0, 32'h0, 8'h00);
      for (int i = 0; i < 16; i++) begin
         check("drain_order", {7'h0, tx_valid, tx_data}, {7'h0, 1'b1, 8'h11 + 8'(i)});
         tick();
      end
      check("drained_valid", {15'h0, tx_valid}, 16'h0000);
      check("drained_full", {15'h0, io_buffer_full}, 16'h0000);

      // two bytes out in order
      tx_ready = 1'b0;
      bus(1'b1, 32'h30000, 8'h41); tick();
      bus(1'b1, 32'h3FFFF, 8'h42); tick();
      bus(1'b0, 32'h0, 8'h00);
      tx_ready = 1'b1;
      check("tx_41", {7'h0, tx_valid, tx_data}, 16'h0141);
      tick();
      check("tx_42", {7'h0, tx_valid, tx_data}, 16'h0142);
      tick();
      check("tx_done", {15'h0, tx_valid}, 16'h0000);

      // async reset in the middle of a read with a loaded FIFO
      tx_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         bus(1'b1, 32'h30000, 8'h50 + 8'(i));
         tick();
      end
      bus(1'b0, 32'h10, 8'h00); tick();
      check("pre_rst_din", {8'h00, mem_din}, 16'h00A5);
      check("pre_rst_full", {15'h0, io_buffer_full}, 16'h0001);
      #2 rst_n_in = 1'b0;
      #1;
      check("midrst_din", {8'h00, mem_din}, 16'h0000);
      check("midrst_valid", {15'h0, tx_valid}, 16'h0000);
      check("midrst_full", {15'h0, io_buffer_full}, 16'h0000);
`ifdef MEM_RESP_DROP_CNT_EN
      check("midrst_drop", drop_cnt, 16'h0000);
`endif
      tick();
      rst_n_in = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
